// File: rtl/wave_seq_ctrl.sv
// Segment sequencer feeding the wave generator's ena / lower / upper inputs.
// Walks a software-loaded table of {mode, lower, upper, duration} segments, once or looping.
module wave_seq_ctrl #(
   parameter int SEG_AW = 3,
   parameter int DUR_W  = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [SEG_AW-1:0] cfg_addr,
   input  logic [2:0]        cfg_mode,
   input  logic [15:0]       cfg_lower,
   input  logic [15:0]       cfg_upper,
   input  logic [DUR_W-1:0]  cfg_dur,
   input  logic [SEG_AW:0]   num_seg,
   input  logic              loop_en,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   output logic [2:0]        gen_ena,
   output logic [15:0]       gen_lower,
   output logic [15:0]       gen_upper,
   output logic [SEG_AW-1:0] seg_idx,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int DEPTH = 2**SEG_AW;
   localparam logic [SEG_AW:0] DEPTH_N = (SEG_AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0]       mode;
      logic [15:0]      lower;
      logic [15:0]      upper;
      logic [DUR_W-1:0] dur;
   } seg_t;

   seg_t              seg_tbl [DEPTH];
   state_t            state, state_nxt;
   logic [SEG_AW-1:0] seg_idx_q, seg_idx_nxt;
   logic [SEG_AW-1:0] last_q, last_nxt;
   logic              loop_q, loop_nxt;
   logic [DUR_W-1:0]  cnt_q, cnt_nxt;
   logic [2:0]        ena_q, ena_nxt;
   logic [15:0]       lower_q, lower_nxt;
   logic [15:0]       upper_q, upper_nxt;
   logic              done_q, done_nxt;
   logic              err_q, err_nxt;
   logic              tbl_wr;
   logic              do_step;
   logic              start_ok;
   logic [SEG_AW:0]   num_m1;
   seg_t              first_seg, next_seg;

   // A zero duration still occupies one cycle so the sequence never stalls.
   function automatic logic [DUR_W-1:0] seg_len(input logic [DUR_W-1:0] d);
      return (d == '0) ? DUR_W'(1) : d;
   endfunction

   assign start_ok  = (num_seg != '0) && (num_seg <= DEPTH_N);
   assign num_m1    = num_seg - (SEG_AW+1)'(1);
   assign first_seg = seg_tbl[0];
   assign next_seg  = seg_tbl[seg_idx_q + SEG_AW'(1)];

   always_comb begin
      state_nxt   = state;
      seg_idx_nxt = seg_idx_q;
      last_nxt    = last_q;
      loop_nxt    = loop_q;
      cnt_nxt     = cnt_q;
      ena_nxt     = ena_q;
      lower_nxt   = lower_q;
      upper_nxt   = upper_q;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      tbl_wr      = 1'b0;
      do_step     = 1'b0;

      if (cfg_we) begin
         if (state == IDLE) tbl_wr  = 1'b1;
         else               err_nxt = 1'b1;
      end

      case (state)
         IDLE: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (start) begin
               if (start_ok) begin
                  last_nxt    = num_m1[SEG_AW-1:0];
                  loop_nxt    = loop_en;
                  seg_idx_nxt = '0;
                  ena_nxt     = first_seg.mode;
                  lower_nxt   = first_seg.lower;
                  upper_nxt   = first_seg.upper;
                  cnt_nxt     = seg_len(first_seg.dur);
                  state_nxt   = RUN;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (stop) begin
               ena_nxt   = '0;
               state_nxt = IDLE;
            end else if (pause) begin
               state_nxt = PAUSE;
            end else begin
               do_step = 1'b1;
            end
         end
         PAUSE: begin
            // Leaving PAUSE performs a normal sequencing step on the same edge.
            if (stop) begin
               ena_nxt   = '0;
               state_nxt = IDLE;
            end else if (!pause) begin
               state_nxt = RUN;
               do_step   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (do_step) begin
         if (cnt_q > DUR_W'(1)) begin
            cnt_nxt = cnt_q - DUR_W'(1);
         end else if (seg_idx_q != last_q) begin
            seg_idx_nxt = seg_idx_q + SEG_AW'(1);
            ena_nxt     = next_seg.mode;
            lower_nxt   = next_seg.lower;
            upper_nxt   = next_seg.upper;
            cnt_nxt     = seg_len(next_seg.dur);
         end else if (loop_q) begin
            seg_idx_nxt = '0;
            ena_nxt     = first_seg.mode;
            lower_nxt   = first_seg.lower;
            upper_nxt   = first_seg.upper;
            cnt_nxt     = seg_len(first_seg.dur);
         end else begin
            ena_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         seg_idx_q <= '0;
         last_q    <= '0;
         loop_q    <= 1'b0;
         cnt_q     <= '0;
         ena_q     <= '0;
         lower_q   <= '0;
         upper_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         seg_idx_q <= seg_idx_nxt;
         last_q    <= last_nxt;
         loop_q    <= loop_nxt;
         cnt_q     <= cnt_nxt;
         ena_q     <= ena_nxt;
         lower_q   <= lower_nxt;
         upper_q   <= upper_nxt;
         done_q    <= done_nxt;
         err_q     <= err_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) seg_tbl[i] <= '0;
      end else if (tbl_wr) begin
         seg_tbl[cfg_addr] <= {cfg_mode, cfg_lower, cfg_upper, cfg_dur};
      end
   end

   assign gen_ena   = ena_q;
   assign gen_lower = lower_q;
   assign gen_upper = upper_q;
   assign seg_idx   = seg_idx_q;
   assign busy      = (state != IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Bench for wave_seq_ctrl: expected per-cycle output traces are built by expanding
// the segment table into cycles, then inserting pause holds and stop/done endings.
module tb_wave_seq_ctrl;

   localparam int SEG_AW = 3;
   localparam int DUR_W  = 24;

   logic              clk;
   logic              rst_n;
   logic              cfg_we;
   logic [SEG_AW-1:0] cfg_addr;
   logic [2:0]        cfg_mode;
   logic [15:0]       cfg_lower;
   logic [15:0]       cfg_upper;
   logic [DUR_W-1:0]  cfg_dur;
   logic [SEG_AW:0]   num_seg;
   logic              loop_en;
   logic              start;
   logic              stop;
   logic              pause;
   logic [2:0]        gen_ena;
   logic [15:0]       gen_lower;
   logic [15:0]       gen_upper;
   logic [SEG_AW-1:0] seg_idx;
   logic              busy;
   logic              done;
   logic              err;

   typedef struct packed {
      logic [2:0]  ena;
      logic [15:0] lower;
      logic [15:0] upper;
      logic [2:0]  idx;
      logic        busy;
      logic        done;
      logic        err;
   } exp_t;

   logic [2:0]       ref_mode  [8];
   logic [15:0]      ref_lower [8];
   logic [15:0]      ref_upper [8];
   logic [DUR_W-1:0] ref_dur   [8];

   int errors = 0;
   int checks = 0;

   wave_seq_ctrl #(.SEG_AW(SEG_AW), .DUR_W(DUR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_mode  (cfg_mode),
      .cfg_lower (cfg_lower),
      .cfg_upper (cfg_upper),
      .cfg_dur   (cfg_dur),
      .num_seg   (num_seg),
      .loop_en   (loop_en),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .gen_ena   (gen_ena),
      .gen_lower (gen_lower),
      .gen_upper (gen_upper),
      .seg_idx   (seg_idx),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) begin
         ref_mode[i] = '0; ref_lower[i] = '0; ref_upper[i] = '0; ref_dur[i] = '0;
      end
   endtask

   function automatic exp_t mk(input logic [2:0] e, input logic [15:0] lo, input logic [15:0] hi,
                               input logic [2:0] ix, input logic b, input logic d);
      exp_t r;
      r.ena = e; r.lower = lo; r.upper = hi; r.idx = ix; r.busy = b; r.done = d; r.err = 1'b0;
      return r;
   endfunction

   // driver: table write while idle
   task automatic write_seg(input int addr, input logic [2:0] m, input logic [15:0] lo,
                            input logic [15:0] hi, input logic [DUR_W-1:0] d);
      cfg_addr = 3'(addr); cfg_mode = m; cfg_lower = lo; cfg_upper = hi; cfg_dur = d;
      cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
      ref_mode[addr] = m; ref_lower[addr] = lo; ref_upper[addr] = hi; ref_dur[addr] = d;
   endtask

   // Runs one sequence. p/l: pause window start/length; s: stop cycle (-1 none);
   // w: cycle of a write attempt while busy (-1 none).
   task automatic run_seq(input string name, input int num, input bit lp, input int p_in,
                          input int l, input int s_in, input int w_in);
      exp_t exp_q[$];
      exp_t e;
      exp_t got;
      int p, s, w, d, term;
      p = p_in; s = s_in; w = w_in;
      if (lp && s < 0) s = 10;
      do begin
         for (int si = 0; si < num; si++) begin
            d = (ref_dur[si] == '0) ? 1 : int'(ref_dur[si]);
            repeat (d) exp_q.push_back(mk(ref_mode[si], ref_lower[si], ref_upper[si], 3'(si), 1'b1, 1'b0));
         end
      end while (lp && exp_q.size() <= s + l + 1);
      if (l > 0) begin
         if (p >= exp_q.size()) p = exp_q.size() - 1;
         e = exp_q[p];
         repeat (l) exp_q.insert(p, e);
      end
      if (s >= 0 && s < exp_q.size()) begin
         while (exp_q.size() > s + 1) exp_q.delete(exp_q.size() - 1);
         e = exp_q[s];
         exp_q.push_back(mk(3'd0, e.lower, e.upper, e.idx, 1'b0, 1'b0));
      end else begin
         s = -1;
         e = exp_q[exp_q.size() - 1];
         exp_q.push_back(mk(3'd0, e.lower, e.upper, e.idx, 1'b0, 1'b1));
      end
      term = exp_q.size() - 1;
      if (w >= term) w = -1;
      if (w >= 0) begin
         e = exp_q[w + 1]; e.err = 1'b1; exp_q[w + 1] = e;
      end
      e = exp_q[term];
      repeat (2) exp_q.push_back(mk(3'd0, e.lower, e.upper, e.idx, 1'b0, 1'b0));

      cfg_we = 1'b0; stop = 1'b0; pause = 1'b0;
      num_seg = 4'(num); loop_en = lp; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
         got = {gen_ena, gen_lower, gen_upper, seg_idx, busy, done, err};
         checks++;
         if (got !== exp_q[k]) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, exp_q[k]);
         end
         pause     = (l > 0) && (k >= p) && (k < p + l);
         stop      = (k == s);
         cfg_we    = (k == w);
         cfg_addr  = 3'($urandom_range(0, 7));
         cfg_mode  = 3'($urandom_range(0, 7));
         cfg_lower = 16'($urandom);
         cfg_upper = 16'($urandom);
         cfg_dur   = DUR_W'($urandom_range(0, 9));
         num_seg   = 4'($urandom_range(0, 15));
         loop_en   = 1'($urandom_range(0, 1));
         step();
      end
      pause = 1'b0; stop = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cfg_we = 0; cfg_addr = 0; cfg_mode = 0; cfg_lower = 0; cfg_upper = 0;
      cfg_dur = 0; num_seg = 0; loop_en = 0; start = 0; stop = 0; pause = 0;
      repeat (3) step();
      rst_n = 1'b1;
      clear_model();
      repeat (5) step();
      checks++; if (gen_ena !== 3'd0) begin errors++; $display("FAIL reset_ena: got %0d expected 0", gen_ena); end
      checks++; if (gen_lower !== 16'd0) begin errors++; $display("FAIL reset_lower: got %0d expected 0", gen_lower); end
      checks++; if (gen_upper !== 16'd0) begin errors++; $display("FAIL reset_upper: got %0d expected 0", gen_upper); end
      checks++; if (seg_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", seg_idx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
   endtask

   task automatic test_two_seg();
      write_seg(0, 3'd2, 16'd0, 16'd255, 24'd4);
      write_seg(1, 3'd1, 16'd16, 16'd31, 24'd3);
      run_seq("two_seg", 2, 1'b0, 0, 0, -1, -1);
   endtask

   task automatic test_loop_stop();
      run_seq("loop_stop", 2, 1'b1, 0, 0, 12, -1);
      run_seq("loop_stop_early", 2, 1'b1, 0, 0, 5, -1);
   endtask

   task automatic test_errors();
      num_seg = 4'd0; start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_num0: got %b expected 1", err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_num0_busy: got %b expected 0", busy); end
      step();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_num0_clear: got %b expected 0", err); end
      num_seg = 4'd9; start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_num9: got %b expected 1", err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_num9_busy: got %b expected 0", busy); end
      run_seq("we_busy", 2, 1'b0, 0, 0, -1, 3);
      run_seq("reread", 2, 1'b0, 0, 0, -1, -1);
   endtask

   task automatic test_start_stop_idle();
      num_seg = 4'd2; start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy: got %b expected 0", busy); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL start_stop_err: got %b expected 0", err); end
      checks++; if (gen_ena !== 3'd0) begin errors++; $display("FAIL start_stop_ena: got %0d expected 0", gen_ena); end
   endtask

   task automatic test_pause();
      write_seg(0, 3'd3, 16'd7, 16'd9, 24'd5);
      run_seq("pause", 1, 1'b0, 1, 3, -1, -1);
   endtask

   task automatic test_dur_zero();
      write_seg(0, 3'd5, 16'd1234, 16'd4321, 24'd0);
      run_seq("dur_zero", 1, 1'b0, 0, 0, -1, -1);
   endtask

   task automatic test_random();
      int num, l, p, s, w;
      bit lp;
      for (int it = 0; it < 10; it++) begin
         for (int a = 0; a < 8; a++)
            write_seg(a, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                      DUR_W'($urandom_range(0, 4)));
         num = $urandom_range(1, 8);
         lp  = 1'($urandom_range(0, 1));
         l   = $urandom_range(0, 3);
         p   = $urandom_range(0, 15);
         if (lp) s = $urandom_range(3, 30);
         else    s = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : -1;
         w   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : -1;
         run_seq("random", num, lp, p, l, s, w);
      end
   endtask

   task automatic test_reset_mid_run();
      exp_t got;
      write_seg(0, 3'd5, 16'd100, 16'd200, 24'd20);
      num_seg = 4'd1; loop_en = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      got = {gen_ena, gen_lower, gen_upper, seg_idx, busy, done, err};
      checks++;
      if (got !== '0) begin errors++; $display("FAIL reset_mid_run: got %h expected 0", got); end
      #1 rst_n = 1'b1;
      clear_model();
      step();
      run_seq("table_cleared", 1, 1'b0, 0, 0, -1, -1);
   endtask

   initial begin
      test_reset();
      test_two_seg();
      test_loop_stop();
      test_errors();
      test_start_stop_idle();
      test_pause();
      test_dur_zero();
      test_random();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
